// File: rtl/blake512_block_sched_if.sv
// Bundle of every signal the BLAKE-512 block sequencer exchanges with the
// message front-end, the core controller and the digest consumer.
// The "slave" modport is the sequencer's view; "master" is the environment's.
interface blake512_block_sched_if;

  // Front-end block descriptor handshake
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;
  logic [10:0]  blk_nbits;

  // Soft clear from the front-end
  logic         abort;

  // Core controller launch / completion strobes
  logic         core_ena;
  logic         core_fin;
  logic         core_clr;
  logic         core_first;
  logic [127:0] core_t;

  // Digest hand-off to the output buffer
  logic         digest_valid;
  logic         digest_ready;

  // Sticky protocol / timeout error
  logic         err;

  modport master (
    output blk_valid, blk_last, blk_nbits, abort,
    output core_fin, core_clr, digest_ready,
    input  blk_ready, core_ena, core_first, core_t, digest_valid, err
  );

  modport slave (
    input  blk_valid, blk_last, blk_nbits, abort,
    input  core_fin, core_clr, digest_ready,
    output blk_ready, core_ena, core_first, core_t, digest_valid, err
  );

endinterface : blake512_block_sched_if

// File: rtl/blake512_block_sched.sv
// Multi-block message sequencer for the BLAKE-512 core.
// Accepts one block descriptor at a time, launches one compression per block,
// keeps the 128-bit message bit counter and the first-block (IV) flag, and
// offers the digest once the final block's compression has been cleared.
// Pure control: no message or chain data passes through this block.
module blake512_block_sched #(
  parameter int unsigned TIMEOUT = 200  // launch-to-core_fin budget, 130..65535
) (
  input  logic                   clk,
  input  logic                   rstb,
  blake512_block_sched_if.slave  bus
);

  localparam int unsigned     WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [10:0]     FULL_BLOCK = 11'd1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_WAIT_CLR,
    S_OUT,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [127:0]    t_acc_q, t_acc_d;
  logic            first_q, first_d;
  logic            last_q,  last_d;
  logic [10:0]     nbits_q, nbits_d;
  logic [WD_W-1:0] wd_q,    wd_d;

  // Handshake qualification and counter update, shared by the next-state logic
  logic            accept;
  logic            bad_len;
  logic            t_carry;
  logic [127:0]    t_sum;
  logic [WD_W-1:0] wd_inc;

  // blk_ready is high exactly in IDLE, so a handshake is IDLE && blk_valid.
  assign accept  = (state_q == S_IDLE) && bus.blk_valid;

  // Only a final block may be partial; nothing may exceed a full block.
  assign bad_len = (bus.blk_nbits > FULL_BLOCK) ||
                   (!bus.blk_last && (bus.blk_nbits != FULL_BLOCK));

  // 129-bit add so a wrap of the 128-bit counter is visible as a carry.
  assign {t_carry, t_sum} = {1'b0, t_acc_q} + {118'd0, bus.blk_nbits};

  // wd_inc is the number of cycles elapsed since the launch cycle, so the
  // timeout fires on the TIMEOUT-1'th cycle after core_ena and err shows
  // TIMEOUT cycles after core_ena.
  assign wd_inc = wd_q + WD_W'(1);

  // State and datapath registers
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      t_acc_q <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      nbits_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      t_acc_q <= t_acc_d;
      first_q <= first_d;
      last_q  <= last_d;
      nbits_q <= nbits_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and register-update logic
  // NOTE: every signal written here gets a hold/default value first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    t_acc_d = t_acc_q;
    first_d = first_q;
    last_d  = last_q;
    nbits_d = nbits_q;
    wd_d    = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.abort) begin
          // Soft clear wins over a coincident descriptor.
          t_acc_d = '0;
          first_d = 1'b1;
        end else if (accept) begin
          if (bad_len || t_carry) begin
            state_d = S_ERR;
          end else begin
            last_d  = bus.blk_last;
            nbits_d = bus.blk_nbits;
            t_acc_d = t_sum;
            state_d = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_BUSY;
      end

      S_BUSY: begin
        wd_d = wd_inc;
        if (bus.core_fin) begin
          // The next block of this message chains from this one, not the IV.
          first_d = 1'b0;
          state_d = S_WAIT_CLR;
        end else if (wd_inc == WD_LIMIT) begin
          state_d = S_ERR;
        end
      end

      S_WAIT_CLR: begin
        // The core must have cleared its registers before the next launch.
        if (bus.core_clr) begin
          state_d = last_q ? S_OUT : S_IDLE;
        end
      end

      S_OUT: begin
        // Consumer take and soft clear both end the message the same way.
        if (bus.digest_ready || bus.abort) begin
          t_acc_d = '0;
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        if (bus.abort) begin
          t_acc_d = '0;
          first_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.blk_ready    = 1'b0;
    bus.core_ena     = 1'b0;
    bus.digest_valid = 1'b0;
    bus.err          = 1'b0;

    unique case (state_q)
      S_IDLE:     bus.blk_ready    = 1'b1;
      S_LAUNCH:   bus.core_ena     = 1'b1;
      S_OUT:      bus.digest_valid = 1'b1;
      S_ERR:      bus.err          = 1'b1;
      default:    ;
    endcase

    bus.core_first = first_q;
    // A padding-only block hashes with counter 0 rather than the running total.
    bus.core_t     = (nbits_q == 11'd0) ? 128'd0 : t_acc_q;
  end

endmodule : blake512_block_sched
